// File: rtl/lin_interp4.sv
// Linear interpolator for a 1-in-4 zero-stuffed sample stream.
// Fills the three stuffed slots between real samples with a floor-rounded ramp.
module lin_interp4 #(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] din,
    input  logic                 din_valid,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    output logic                 underrun,
    output logic                 overrun
);

    localparam logic [2:0] HOLD = 3'd4;

    logic signed [DW-1:0] prev;
    logic signed [DW-1:0] cur;
    logic [2:0]           phase;
    logic [1:0]           primed;

    logic signed [DW+3:0] diff;
    logic signed [DW+3:0] prod;
    logic signed [DW+3:0] step;
    logic signed [DW+3:0] interp;
    logic                 unused_hi;

    // Wide intermediates keep the product exact; the result always lies
    // between prev and cur, so the top bits are never needed.
    always_comb begin
        diff   = {{4{cur[DW-1]}}, cur} - {{4{prev[DW-1]}}, prev};
        prod   = diff * $signed({{(DW+1){1'b0}}, phase});
        step   = prod >>> 2;
        interp = {{4{prev[DW-1]}}, prev} + step;
    end

    assign unused_hi = ^interp[DW+3:DW];

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '0;
            cur        <= '0;
            phase      <= HOLD;
            primed     <= 2'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            underrun <= !din_valid && (phase == 3'd3);
            overrun  <= din_valid && (phase < 3'd3) && (primed != 2'd0);

            if (din_valid) begin
                prev  <= cur;
                cur   <= din;
                phase <= 3'd0;
                if (primed != 2'd2) begin
                    primed <= primed + 2'd1;
                end
            end else if (phase < HOLD) begin
                phase <= phase + 3'd1;
            end

            // Output stays zero until two real samples define a ramp.
            dout_valid <= (primed == 2'd2);
            dout       <= (primed == 2'd2) ? interp[DW-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_lin_interp4.sv
// Bench for lin_interp4: directed and random sample streams against a
// ramp-formula reference model, checked by a scoreboard every cycle.
module tb_lin_interp4;

    logic              clk;
    logic              reset;
    logic signed [7:0] din;
    logic              din_valid;
    logic signed [7:0] dout;
    logic              dout_valid;
    logic              underrun;
    logic              overrun;

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle output: {dout_valid, dout[7:0], underrun, overrun}
    logic [10:0] exp_q[$];

    // Reference model state: last two samples, cycles since newest, count
    int m_old;
    int m_new;
    int m_age;
    int m_count;

    lin_interp4 #(.DW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .underrun   (underrun),
        .overrun    (overrun)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int floor_div4(input int x);
        int r;
        r = ((x % 4) + 4) % 4;
        return (x - r) / 4;
    endfunction

    // Value k quarters of the way from a to b, floor rounded.
    function automatic int ramp(input int a, input int b, input int k);
        return a + floor_div4((b - a) * k);
    endfunction

    task automatic model_edge(input bit r, input bit v, input int d);
        logic       ev;
        logic [7:0] ed;
        logic       eu;
        logic       eo;
        if (r) begin
            ev = 1'b0; ed = 8'd0; eu = 1'b0; eo = 1'b0;
            m_old = 0; m_new = 0; m_age = 4; m_count = 0;
        end else begin
            ev = (m_count >= 2);
            ed = ev ? 8'(ramp(m_old, m_new, m_age)) : 8'd0;
            eu = !v && (m_age == 3);
            eo = v && (m_age < 3) && (m_count >= 1);
            if (v) begin
                m_old   = m_new;
                m_new   = d;
                m_age   = 0;
                m_count = m_count + 1;
            end else if (m_age < 4) begin
                m_age = m_age + 1;
            end
        end
        exp_q.push_back({ev, ed, eu, eo});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, input bit v, input int d);
        reset     = r;
        din_valid = v;
        din       = 8'(d);
        @(posedge clk);
        model_edge(r, v, d);
        #1;
    endtask

    // One real sample followed by gap-1 stuffed cycles.
    task automatic send(input int d, input int gap);
        drive(1'b0, 1'b1, d);
        for (int i = 1; i < gap; i++) begin
            drive(1'b0, 1'b0, 0);
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b1, 1'b0, 0);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            logic [10:0] a;
            e = exp_q.pop_front();
            a = {dout_valid, dout, underrun, overrun};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL out_cycle t=%0t: got valid=%0b dout=%0d under=%0b over=%0b, required valid=%0b dout=%0d under=%0b over=%0b",
                         $time, a[10], $signed(a[9:2]), a[1], a[0],
                         e[10], $signed(e[9:2]), e[1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        m_old = 0; m_new = 0; m_age = 4; m_count = 0;

        // Ramp up from 0 to 100 into a continuing stream
        do_reset(2);
        send(0, 4);
        send(100, 4);
        send(-100, 4);   // negative slope 100 -> -100
        send(0, 4);
        send(-1, 4);     // floor rounding 0 -> -1
        send(-128, 4);
        send(127, 4);    // full scale -128 -> 127
        send(0, 4);
        send(40, 12);    // starvation: hold at 40, single underrun

        // Early valid two cycles after the previous one
        send(-60, 4);
        send(20, 2);
        send(90, 4);
        send(-30, 4);

        // Reset mid-ramp for one cycle, then re-prime
        send(70, 2);
        do_reset(1);
        drive(1'b0, 1'b0, 0);
        send(10, 4);
        send(-50, 4);
        send(30, 6);

        // Randomized spacing, values and occasional reset
        for (int n = 0; n < 400; n++) begin
            int d;
            int gap;
            d   = int'($urandom_range(0, 255)) - 128;
            gap = ($urandom_range(0, 9) < 7) ? 4 : int'($urandom_range(1, 7));
            if ($urandom_range(0, 49) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end
            send(d, gap);
        end

        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected outputs, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
